// File: rtl/display_scanner.sv
// Seven-segment scan driver: walks four active-low anodes with a blanking gap at the start
// of each slot. It latches display data through a valid/ready handshake and commits it only
// at frame boundaries, so a frame never shows a mix of old and new data.
module display_scanner #(
   parameter int unsigned DIGIT_PERIOD = 100000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       display_en,
   input  logic       upd_valid,
   output logic       upd_ready,
   input  logic [5:0] value_in,
   input  logic       negative_in,
   input  logic       is_dec_in,
   output logic [3:0] digit,
   output logic [5:0] display_value,
   output logic       show_negative,
   output logic       is_dec,
   output logic       frame_start
);

   localparam int unsigned CntW = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
   localparam logic [CntW-1:0] CntLast  = CntW'(DIGIT_PERIOD - 1);
   localparam logic [CntW-1:0] CntBlank = CntW'(BLANK_CYCLES);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      idx_q, idx_d;
   logic [3:0]      digit_q, digit_d;
   logic            pending_q, pending_d;
   logic [7:0]      shadow_q, shadow_d;    // {value, negative, is_dec}
   logic [7:0]      commit_q, commit_d;
   logic            frame_start_q;
   logic            boundary;
   logic            xfer;

   // Slot counter and digit index; the boundary is the last cycle of slot 3.
   always_comb begin
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      boundary = (idx_q == 2'd3) && (cnt_q == CntLast);
      if (cnt_q == CntLast) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // Anode pattern computed from the next counter state so the registered output lines up
   // with cnt/idx in the same cycle.
   always_comb begin
      digit_d = 4'b1111;
      if (display_en && (cnt_d >= CntBlank)) begin
         unique case (idx_d)
            2'd0: digit_d = 4'b1110;
            2'd1: digit_d = 4'b1101;
            2'd2: digit_d = 4'b1011;
            2'd3: digit_d = 4'b0111;
            default: digit_d = 4'b1111;
         endcase
      end
   end

   // Handshake capture and frame-boundary commit. While pending, ready is low so no
   // transfer can collide with the shadow-to-output copy.
   always_comb begin
      xfer      = upd_valid && !pending_q;
      pending_d = pending_q;
      shadow_d  = shadow_q;
      commit_d  = commit_q;
      if (boundary) begin
         if (pending_q) begin
            commit_d  = shadow_q;
            pending_d = 1'b0;
         end else if (xfer) begin
            // Offer on the boundary itself goes straight to the outputs.
            commit_d = {value_in, negative_in, is_dec_in};
         end
      end else if (xfer) begin
         shadow_d  = {value_in, negative_in, is_dec_in};
         pending_d = 1'b1;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         idx_q         <= 2'd0;
         digit_q       <= 4'b1111;
         pending_q     <= 1'b0;
         shadow_q      <= 8'd0;
         commit_q      <= 8'd0;
         frame_start_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         digit_q       <= digit_d;
         pending_q     <= pending_d;
         shadow_q      <= shadow_d;
         commit_q      <= commit_d;
         frame_start_q <= boundary;
      end
   end

   assign upd_ready     = !pending_q;
   assign digit         = digit_q;
   assign display_value = commit_q[7:2];
   assign show_negative = commit_q[1];
   assign is_dec        = commit_q[0];
   assign frame_start   = frame_start_q;

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with an 8-cycle slot and a 2-cycle blanking gap.
module tb_display_scanner;

   localparam int unsigned DP = 8;
   localparam int unsigned BL = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       display_en = 1'b1;
   logic       upd_valid = 1'b0;
   logic [5:0] value_in = 6'd0;
   logic       negative_in = 1'b0;
   logic       is_dec_in = 1'b0;
   logic       upd_ready;
   logic [3:0] digit;
   logic [5:0] display_value;
   logic       show_negative;
   logic       is_dec;
   logic       frame_start;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   display_scanner #(
      .DIGIT_PERIOD(DP),
      .BLANK_CYCLES(BL)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .display_en   (display_en),
      .upd_valid    (upd_valid),
      .upd_ready    (upd_ready),
      .value_in     (value_in),
      .negative_in  (negative_in),
      .is_dec_in    (is_dec_in),
      .digit        (digit),
      .display_value(display_value),
      .show_negative(show_negative),
      .is_dec       (is_dec),
      .frame_start  (frame_start)
   );

   always #5 clk = ~clk;

   // Expected anode pattern for cycle c after reset release, display enabled.
   function automatic logic [3:0] exp_digit(input int c);
      int k;
      int i;
      k = c % DP;
      i = (c / DP) % 4;
      if (k < BL) return 4'b1111;
      case (i)
         0: return 4'b1110;
         1: return 4'b1101;
         2: return 4'b1011;
         default: return 4'b0111;
      endcase
   endfunction

   // Cycle n is sampled/driven 1 time unit after the n-th rising edge following release.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick();
   endtask

   task automatic release_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc = 0;
   endtask

   task automatic do_reset();
      upd_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      release_reset();
   endtask

   task automatic offer(input logic [5:0] v, input logic n, input logic d);
      upd_valid   = 1'b1;
      value_in    = v;
      negative_in = n;
      is_dec_in   = d;
   endtask

   task automatic test_reset();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({digit, display_value, show_negative, is_dec, frame_start, upd_ready} !==
          {4'b1111, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL reset_state: got digit=%b val=%0d neg=%b dec=%b fs=%b rdy=%b",
                  digit, display_value, show_negative, is_dec, frame_start, upd_ready);
      end
      release_reset();
      for (int c = 0; c <= 65; c++) begin
         run_to(c);
         checks++;
         if (digit !== exp_digit(c)) begin
            failures++;
            $display("FAIL scan_digit c=%0d: got %b want %b", c, digit, exp_digit(c));
         end
         checks++;
         if (frame_start !== (c > 0 && c % 32 == 0)) begin
            failures++;
            $display("FAIL frame_start c=%0d: got %b want %b", c, frame_start,
                     (c > 0 && c % 32 == 0));
         end
      end
   endtask

   task automatic test_accept();
      do_reset();
      run_to(12);
      checks++;
      if (upd_ready !== 1'b1) begin
         failures++;
         $display("FAIL accept_ready_idle: got %b want 1", upd_ready);
      end
      offer(6'd42, 1'b1, 1'b1);
      tick();
      upd_valid = 1'b0;
      for (int c = 13; c <= 31; c++) begin
         run_to(c);
         checks++;
         if ({upd_ready, display_value, show_negative, is_dec} !== {1'b0, 6'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL accept_hold c=%0d: got rdy=%b val=%0d neg=%b dec=%b want 0/0/0/0",
                     c, upd_ready, display_value, show_negative, is_dec);
         end
      end
      run_to(32);
      checks++;
      if ({upd_ready, display_value, show_negative, is_dec} !== {1'b1, 6'd42, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL accept_commit: got rdy=%b val=%0d neg=%b dec=%b want 1/42/1/1",
                  upd_ready, display_value, show_negative, is_dec);
      end
   endtask

   task automatic test_ignore_busy();
      do_reset();
      run_to(12);
      offer(6'd5, 1'b0, 1'b0);
      tick();
      upd_valid = 1'b0;
      run_to(20);
      offer(6'd9, 1'b1, 1'b1);
      for (int c = 20; c <= 31; c++) begin
         run_to(c);
         checks++;
         if ({upd_ready, display_value} !== {1'b0, 6'd0}) begin
            failures++;
            $display("FAIL busy_hold c=%0d: got rdy=%b val=%0d want 0/0", c, upd_ready,
                     display_value);
         end
      end
      upd_valid = 1'b0;
      run_to(32);
      checks++;
      if ({display_value, show_negative, is_dec} !== {6'd5, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL busy_commit: got val=%0d neg=%b dec=%b want 5/0/0", display_value,
                  show_negative, is_dec);
      end
      run_to(64);
      checks++;
      if (display_value !== 6'd5) begin
         failures++;
         $display("FAIL busy_no_late: got val=%0d want 5", display_value);
      end
   endtask

   task automatic test_bypass();
      do_reset();
      for (int c = 0; c <= 33; c++) begin
         run_to(c);
         checks++;
         if (upd_ready !== 1'b1) begin
            failures++;
            $display("FAIL bypass_ready c=%0d: got %b want 1", c, upd_ready);
         end
         if (c == 31) begin
            checks++;
            if (display_value !== 6'd0) begin
               failures++;
               $display("FAIL bypass_before: got val=%0d want 0", display_value);
            end
            offer(6'd63, 1'b0, 1'b1);
         end
         if (c == 32) begin
            checks++;
            if ({display_value, show_negative, is_dec} !== {6'd63, 1'b0, 1'b1}) begin
               failures++;
               $display("FAIL bypass_commit: got val=%0d neg=%b dec=%b want 63/0/1",
                        display_value, show_negative, is_dec);
            end
            upd_valid = 1'b0;
         end
      end
   endtask

   task automatic test_blanked();
      display_en = 1'b0;
      do_reset();
      for (int c = 0; c <= 64; c++) begin
         run_to(c);
         checks++;
         if (digit !== 4'b1111) begin
            failures++;
            $display("FAIL blank_digit c=%0d: got %b want 1111", c, digit);
         end
         checks++;
         if (frame_start !== (c == 32 || c == 64)) begin
            failures++;
            $display("FAIL blank_frame c=%0d: got %b want %b", c, frame_start,
                     (c == 32 || c == 64));
         end
         if (c == 3) offer(6'd17, 1'b0, 1'b1);
         if (c == 4) upd_valid = 1'b0;
         if (c == 32) begin
            checks++;
            if ({display_value, is_dec} !== {6'd17, 1'b1}) begin
               failures++;
               $display("FAIL blank_commit: got val=%0d dec=%b want 17/1", display_value, is_dec);
            end
         end
      end
      display_en = 1'b1;
   endtask

   task automatic test_back_to_back();
      do_reset();
      run_to(12);
      offer(6'd20, 1'b0, 1'b0);
      tick();
      upd_valid = 1'b0;
      run_to(32);
      checks++;
      if ({display_value, upd_ready} !== {6'd20, 1'b1}) begin
         failures++;
         $display("FAIL b2b_first: got val=%0d rdy=%b want 20/1", display_value, upd_ready);
      end
      offer(6'd33, 1'b1, 1'b0);
      tick();
      upd_valid = 1'b0;
      checks++;
      if ({display_value, upd_ready} !== {6'd20, 1'b0}) begin
         failures++;
         $display("FAIL b2b_accept: got val=%0d rdy=%b want 20/0", display_value, upd_ready);
      end
      run_to(63);
      checks++;
      if (display_value !== 6'd20) begin
         failures++;
         $display("FAIL b2b_hold: got val=%0d want 20", display_value);
      end
      run_to(64);
      checks++;
      if ({display_value, show_negative, is_dec, upd_ready} !== {6'd33, 1'b1, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL b2b_second: got val=%0d neg=%b dec=%b rdy=%b want 33/1/0/1",
                  display_value, show_negative, is_dec, upd_ready);
      end
   endtask

   task automatic test_reset_midframe();
      do_reset();
      run_to(5);
      offer(6'd7, 1'b1, 1'b1);
      tick();
      upd_valid = 1'b0;
      run_to(20);
      checks++;
      if (upd_ready !== 1'b0) begin
         failures++;
         $display("FAIL mid_pending: got rdy=%b want 0", upd_ready);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({digit, display_value, show_negative, is_dec, frame_start, upd_ready} !==
          {4'b1111, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL mid_async_clear: got digit=%b val=%0d neg=%b dec=%b fs=%b rdy=%b",
                  digit, display_value, show_negative, is_dec, frame_start, upd_ready);
      end
      release_reset();
      for (int c = 0; c <= 70; c++) begin
         run_to(c);
         checks++;
         if ({display_value, show_negative, is_dec, upd_ready} !== {6'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL mid_discard c=%0d: got val=%0d neg=%b dec=%b rdy=%b want 0/0/0/1",
                     c, display_value, show_negative, is_dec, upd_ready);
         end
         checks++;
         if (digit !== exp_digit(c)) begin
            failures++;
            $display("FAIL mid_restart c=%0d: got %b want %b", c, digit, exp_digit(c));
         end
      end
   endtask

   initial begin
      test_reset();
      test_accept();
      test_ignore_busy();
      test_bypass();
      test_blanked();
      test_back_to_back();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
